// File: rtl/fb_arbiter_pkg.sv
// Framebuffer geometry plus the pixel coordinate and color formats shared by the
// arbiter, its address calculator and anything that talks to the framebuffer.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

package fb_arbiter_pkg;
    localparam int FB_WIDTH  = `WIDTH;
    localparam int FB_HEIGHT = `HEIGHT;
    localparam int FB_ADDR_W = 19;
    localparam int COORD_W   = 16;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } Point2D;

    typedef logic [23:0] Color;
endpackage

// File: rtl/fb_addr_calc.sv
// Combinational Point2D -> linear framebuffer address, with an on-screen flag.
// The address is meaningless when in_range is low.
module fb_addr_calc import fb_arbiter_pkg::*; #(
    parameter int ADDR_W = FB_ADDR_W
) (
    input  Point2D              pt,
    output logic [ADDR_W-1:0]   addr,
    output logic                in_range
);
    localparam coord_t WIDTH_C  = coord_t'(FB_WIDTH);
    localparam coord_t HEIGHT_C = coord_t'(FB_HEIGHT);

    // Sign bits reject negative coordinates before the signed upper-bound compare.
    assign in_range = !pt.x[COORD_W-1] && !pt.y[COORD_W-1] &&
                      (pt.x < WIDTH_C) && (pt.y < HEIGHT_C);

    assign addr = ADDR_W'(pt.y) * ADDR_W'(FB_WIDTH) + ADDR_W'(pt.x);
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads, clear writes and line-pixel writes,
// one access per cycle, with a starvation override that lets a waiting writer beat scanout.
module fb_arbiter import fb_arbiter_pkg::*; #(
    parameter int   ADDR_W       = FB_ADDR_W,
    parameter int   RD_LAT       = 2,
    parameter int   STARVE_LIMIT = 15,
    parameter Color CLEAR_COLOR  = 24'h000000
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                rd_req,
    input  Point2D              rd_point,
    output logic                rd_gnt,
    output logic                rd_valid,
    output Color                rd_data,
    input  logic                clr_req,
    input  Point2D              clr_point,
    output logic                clr_gnt,
    input  logic                pix_req,
    input  Point2D              pix_point,
    input  Color                pix_color,
    output logic                pix_gnt,
    output logic [ADDR_W-1:0]   mem_addr,
    output Color                mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  Color                mem_rdata,
    output logic [15:0]         drop_cnt,
    output logic                idle
);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]        clr_starve, pix_starve;
    logic              clr_hot, pix_hot, wr_gnt, in_range;
    Point2D            win_point;
    logic [ADDR_W-1:0] win_addr;
    // Stage 0 lines up with mem_re, stage RD_LAT with rd_valid.
    logic [RD_LAT:0]   rd_vld_pipe, rd_hit_pipe;

    assign clr_hot = clr_req && (clr_starve == STARVE_MAX);
    assign pix_hot = pix_req && (pix_starve == STARVE_MAX);
    assign wr_gnt  = clr_gnt || pix_gnt;

    // A starved writer only pushes scanout aside; between writers clr always wins.
    always_comb begin
        rd_gnt    = 1'b0;
        clr_gnt   = 1'b0;
        pix_gnt   = 1'b0;
        win_point = pix_point;
        if (rd_req && !clr_hot && !pix_hot) begin
            rd_gnt    = 1'b1;
            win_point = rd_point;
        end else if (clr_req) begin
            clr_gnt   = 1'b1;
            win_point = clr_point;
        end else if (pix_req) begin
            pix_gnt   = 1'b1;
        end
    end

    fb_addr_calc #(.ADDR_W(ADDR_W)) u_addr_calc (
        .pt       (win_point),
        .addr     (win_addr),
        .in_range (in_range)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clr_starve <= '0;
            pix_starve <= '0;
        end else begin
            if (!clr_req || clr_gnt)
                clr_starve <= '0;
            else if (clr_starve != STARVE_MAX)
                clr_starve <= clr_starve + 4'd1;
            if (!pix_req || pix_gnt)
                pix_starve <= '0;
            else if (pix_starve != STARVE_MAX)
                pix_starve <= pix_starve + 4'd1;
        end
    end

    // Off-screen accesses are granted so upstream moves on, but never reach the SRAM.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            drop_cnt  <= '0;
        end else begin
            mem_we <= wr_gnt && in_range;
            mem_re <= rd_gnt && in_range;
            if ((rd_gnt || wr_gnt) && in_range)
                mem_addr <= win_addr;
            if (wr_gnt && in_range)
                mem_wdata <= clr_gnt ? CLEAR_COLOR : pix_color;
            if (wr_gnt && !in_range && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_vld_pipe <= '0;
            rd_hit_pipe <= '0;
        end else begin
            rd_vld_pipe <= {rd_vld_pipe[RD_LAT-1:0], rd_gnt};
            rd_hit_pipe <= {rd_hit_pipe[RD_LAT-1:0], rd_gnt && in_range};
        end
    end

    assign rd_valid = rd_vld_pipe[RD_LAT];
    assign rd_data  = (rd_valid && rd_hit_pipe[RD_LAT]) ? mem_rdata : '0;

    assign idle = !rd_req && !clr_req && !pix_req && !mem_we && !mem_re && !(|rd_vld_pipe);
endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-ported framebuffer memory among three requesters, one access per cycle:
  - display scanout reads;
  - rasterizer clear writes;
  - Bresenham line-pixel writes.
- Sits between rasterizer_controller/line drawer and the framebuffer SRAM.
- Converts Point2D to a linear address, drops off-screen writes, and enforces a starvation bound on writers.
- Reports when all accepted traffic has drained, so the controller does not signal done early.

Parameters:
- ADDR_W, 19, framebuffer address width.
- RD_LAT, 2, memory read latency in cycles from mem_re to valid mem_rdata (1..4).
- STARVE_LIMIT, 15, consecutive denied cycles after which a writer preempts scanout.
- CLEAR_COLOR, 24'h000000, color written for clear requests.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous, active-low reset
- rd_req  in  1  scanout read request
- rd_point  in  Point2D  pixel to read
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_data valid
- rd_data  out  Color  returned pixel
- clr_req  in  1  clear write request
- clr_point  in  Point2D  pixel to clear
- clr_gnt  out  1  clear accepted this cycle (combinational)
- pix_req  in  1  line pixel write request
- pix_point  in  Point2D  pixel to write
- pix_color  in  Color  pixel color
- pix_gnt  out  1  pixel accepted this cycle (combinational)
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  Color  registered write data
- mem_we  out  1  registered write enable
- mem_re  out  1  registered read enable
- mem_rdata  in  Color  read data
- drop_cnt  out  16  saturating count of discarded off-screen writes
- idle  out  1  no request pending, no memory op issued, no read in flight

Behaviour:
- Reset: all gnt = 0, mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0, rd_valid = 0, rd_data = 0, drop_cnt = 0, starve counters = 0, idle = 1.
- Transfer rule:
  - A transfer occurs on a clock edge where req && gnt.
  - Requester holds req and its point/color stable until granted.
  - At most one gnt is high per cycle; gnt is never high without its req.
- Priority:
  - Default order is rd > clr > pix.
  - Override: a writer whose starve counter == STARVE_LIMIT beats rd.
  - If both writers are at the limit, clr wins.
- Starve counters (4-bit, one each for clr and pix):
  - Increment on each cycle with req && !gnt, saturating at STARVE_LIMIT.
  - Clear on gnt or when req is low.
- Address: mem_addr = y*`WIDTH + x, computed combinationally for the winner and registered on the grant edge.
- Writes:
  - Registered: mem_we is high for exactly the cycle after the grant.
  - mem_wdata = CLEAR_COLOR for clr, pix_color for pix.
- Off-screen writes:
  - A write with x >= `WIDTH or y >= `HEIGHT (signed, negative included) is still granted.
  - mem_we stays 0 and drop_cnt increments, saturating at 16'hFFFF.
- Reads:
  - mem_re is high the cycle after the grant.
  - rd_valid pulses exactly RD_LAT cycles after mem_re, with rd_data = mem_rdata sampled that cycle.
  - The read pipeline is an RD_LAT-deep valid shift register and accepts one read per cycle back-to-back.
  - Off-screen reads are granted, mem_re stays 0, and rd_valid still pulses on schedule with rd_data = 0.
- Simultaneous events: a grant, a memory issue from the prior grant, and a read return may all occur in the same cycle; none of them stall.
- idle = !rd_req && !clr_req && !pix_req && !mem_we && !mem_re && no valid bit in the read pipeline.
- Reset mid-operation:
  - In-flight reads are discarded; rd_valid is not raised for them.
  - A write issued but not yet on mem_we is lost. Upstream restarts from reset.

Decomposition:
- defines_package: Point2D, Color, `WIDTH, `HEIGHT (existing); add the FB_ADDR_W constant.
- Sub-module fb_addr_calc, combinational: Point2D in, address plus in_range out. Used for the winner's point.

Test Plan:
- Single pix_req at (3,2), color 24'hFF0000, RD_LAT=2 → pix_gnt in the same cycle; next cycle mem_we=1, mem_addr=2*`WIDTH+3, mem_wdata=24'hFF0000; idle=1 two cycles after req drops.
- rd_req at (0,1) with model memory holding 24'h123456 → mem_re one cycle after grant, addr=`WIDTH; rd_valid with rd_data=24'h123456 exactly 2 cycles later.
- clr_req and pix_req held together, no rd → clr granted every cycle; after 15 denied cycles pix is still denied, because the override only beats rd and clr still wins over pix.
- rd_req held continuously with pix_req → pix granted on the 16th request cycle (counter reached 15), then rd resumes; repeats with period 16.
- pix_point (`WIDTH, 0) then (-1, 5) → both granted, mem_we never asserted, drop_cnt 0→1→2.
- Back-to-back reads on 4 consecutive cycles, n_rst pulsed after the 2nd rd_valid → exactly 2 rd_valid pulses; after reset all outputs are at reset values and idle=1.
